// File: rtl/a2d_intf.sv
// a2d_intf: round-robin ADC128S SPI interface filling lft_ld/rght_ld/steer_pot/batt.
// Optional A2D_AUTO_NXT_EN: an internal 14-bit timer requests a conversion every 16384 clk.
module a2d_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt
);

    localparam logic [2:0] LFT_CH   = 3'd0;
    localparam logic [2:0] RGHT_CH  = 3'd4;
    localparam logic [2:0] STEER_CH = 3'd5;
    localparam logic [2:0] BATT_CH  = 3'd6;

    typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

    state_t      state, nxt_state;
    logic [1:0]  ptr;
    logic [2:0]  ch;
    logic [15:0] cmd;
    logic        start;
    logic        nxt_req;

    logic        ss_n_r;
    logic [3:0]  sdiv;
    logic [4:0]  rise_cnt;
    logic [15:0] tx_sr;
    logic [15:0] rx_sr;
    logic        spi_done;
    logic        unused_rx;

`ifdef A2D_AUTO_NXT_EN
    logic [13:0] auto_tmr;
    logic        unused_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            auto_tmr <= 14'd0;
        else
            auto_tmr <= auto_tmr + 14'd1;
    end

    assign nxt_req    = &auto_tmr;
    assign unused_nxt = nxt;
`else
    assign nxt_req = nxt;
`endif

    always_comb begin
        ch = LFT_CH;
        case (ptr)
            2'd1:    ch = RGHT_CH;
            2'd2:    ch = STEER_CH;
            2'd3:    ch = BATT_CH;
            default: ch = LFT_CH;
        endcase
    end

    assign cmd = {2'b00, ch, 11'h000};

    // SPI engine: sdiv starts at 8 so SCLK gives an 8-clk front porch before the first fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_r   <= 1'b1;
            sdiv     <= 4'b1000;
            rise_cnt <= 5'd0;
            tx_sr    <= 16'h0000;
            spi_done <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            if (start) begin
                ss_n_r   <= 1'b0;
                sdiv     <= 4'b1000;
                rise_cnt <= 5'd0;
                tx_sr    <= cmd;
            end else if (!ss_n_r) begin
                if (rise_cnt == 5'd16 && sdiv == 4'hF) begin
                    ss_n_r   <= 1'b1;
                    spi_done <= 1'b1;
                end else begin
                    sdiv <= sdiv + 4'd1;
                    if (sdiv == 4'b0111)
                        rise_cnt <= rise_cnt + 5'd1;
                    // The front-porch fall keeps bit 15 so the ADC sees it on the first rise
                    if (sdiv == 4'hF && rise_cnt != 5'd0)
                        tx_sr <= {tx_sr[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!ss_n_r && sdiv == 4'b0111)
            rx_sr <= {rx_sr[14:0], MISO};
    end

    assign SS_n      = ss_n_r;
    assign SCLK      = sdiv[3];
    assign MOSI      = tx_sr[15];
    assign unused_rx = ^rx_sr[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (nxt_req)  nxt_state = CMD;
            CMD:     if (spi_done) nxt_state = GAP;
            GAP:     nxt_state = READ;
            READ:    if (spi_done) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        start     = 1'b0;
        cnv_cmplt = 1'b0;
        case (state)
            IDLE:    start     = nxt_req;
            GAP:     start     = 1'b1;
            DONE:    cnv_cmplt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 2'd0;
        else if (state == DONE)
            ptr <= ptr + 2'd1;
    end

    // Result lands on the READ->DONE edge so it is already visible while cnv_cmplt is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else if (state == READ && spi_done) begin
            case (ptr)
                2'd0:    lft_ld    <= rx_sr[11:0];
                2'd1:    rght_ld   <= rx_sr[11:0];
                2'd2:    steer_pot <= rx_sr[11:0];
                default: batt      <= rx_sr[11:0];
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural ADC128S model on the SPI pins.
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        MISO;
    logic        SS_n, SCLK, MOSI;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    a2d_intf dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .MISO(MISO),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
        .cnv_cmplt(cnv_cmplt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC128S model: returns the channel addressed by the previous frame
    logic [11:0] lft_v = 12'h0, rght_v = 12'h0, steer_v = 12'h0, batt_v = 12'h0;
    logic [15:0] miso_sr = 16'hA5A5;
    logic [15:0] mosi_sr = 16'h0;
    logic [2:0]  prev_ch = 3'd0;
    logic        ss_q = 1'b1, sclk_q = 1'b1;
    int          nrise = 0, nfall = 0, bad_edges = 0;
    logic [15:0] mosi_q [$];
    int          rise_q [$];
    int          fall_q [$];

    assign MISO = miso_sr[15];

    function automatic logic [11:0] ch_val(input logic [2:0] c);
        case (c)
            3'd0:    return lft_v;
            3'd4:    return rght_v;
            3'd5:    return steer_v;
            3'd6:    return batt_v;
            default: return 12'h000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (ss_q && !SS_n) begin
            miso_sr = {4'h0, ch_val(prev_ch)};
            mosi_sr = 16'h0;
            nrise = 0;
            nfall = 0;
        end else if (!SS_n && sclk_q && !SCLK) begin
            nfall++;
            if (nfall > 1) miso_sr = {miso_sr[14:0], 1'b0};
        end
        if (!SS_n && !sclk_q && SCLK) begin
            mosi_sr = {mosi_sr[14:0], MOSI};
            nrise++;
        end
        if (SS_n && ss_q && (SCLK !== sclk_q)) bad_edges++;
        if (!ss_q && SS_n) begin
            prev_ch = mosi_sr[13:11];
            mosi_q.push_back(mosi_sr);
            rise_q.push_back(nrise);
            fall_q.push_back(nfall);
        end
        ss_q   = SS_n;
        sclk_q = SCLK;
    end

    task automatic clear_logs;
        mosi_q.delete();
        rise_q.delete();
        fall_q.delete();
        bad_edges = 0;
    endtask

    task automatic do_reset;
        nxt = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
    endtask

    // Called at a negedge: nxt is high for one cycle (cycle 0), optionally again at extra_at
    task automatic measure(input int extra_at, output int f1, output int r1, output int f2,
                           output int r2, output int cc, output logic [47:0] regs);
        int t0, rel;
        f1 = -1; r1 = -1; f2 = -1; r2 = -1; cc = -1; regs = '0;
        nxt = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 700; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            nxt = (rel == extra_at);
            if (!SS_n && f1 < 0) f1 = rel;
            else if (SS_n && f1 >= 0 && r1 < 0) r1 = rel;
            else if (!SS_n && r1 >= 0 && f2 < 0) f2 = rel;
            else if (SS_n && f2 >= 0 && r2 < 0) r2 = rel;
            if (cnv_cmplt) begin
                cc = rel;
                regs = {lft_ld, rght_ld, steer_pot, batt};
                break;
            end
        end
        nxt = 1'b0;
    endtask

    task automatic test_reset;
        lft_v = 12'hFFF; rght_v = 12'hABC; steer_v = 12'h123; batt_v = 12'h456;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (SS_n !== 1'b1) begin bad++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL rst_sclk: got %b want 1", SCLK); end
        total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
        total++; if (cnv_cmplt !== 1'b0) begin bad++; $display("FAIL rst_cmplt: got %b want 0", cnv_cmplt); end
        total++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
            bad++; $display("FAIL rst_regs: got %h want 0", {lft_ld, rght_ld, steer_pot, batt}); end
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic test_single;
        int f1, r1, f2, r2, cc;
        logic [47:0] regs;
        do_reset();
        lft_v = 12'h300; rght_v = 12'h111; steer_v = 12'h222; batt_v = 12'h333;
        measure(-1, f1, r1, f2, r2, cc, regs);
        total++; if (f1 != 1)   begin bad++; $display("FAIL single_fall1: got %0d want 1", f1); end
        total++; if (r1 != 265) begin bad++; $display("FAIL single_rise1: got %0d want 265", r1); end
        total++; if (f2 != 267) begin bad++; $display("FAIL single_fall2: got %0d want 267", f2); end
        total++; if (r2 != 531) begin bad++; $display("FAIL single_rise2: got %0d want 531", r2); end
        total++; if (cc != 532) begin bad++; $display("FAIL single_cmplt: got %0d want 532", cc); end
        total++; if (regs !== {12'h300, 36'h0}) begin bad++; $display("FAIL single_regs: got %h want %h", regs, {12'h300, 36'h0}); end
        @(negedge clk);
        total++; if (cnv_cmplt !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", cnv_cmplt); end
        total++; if (mosi_q.size() != 2) begin bad++; $display("FAIL single_frames: got %0d want 2", mosi_q.size()); end
        for (int k = 0; k < 2; k++) begin
            total++; if (mosi_q[k] !== 16'h0000) begin bad++; $display("FAIL single_mosi%0d: got %h want 0000", k, mosi_q[k]); end
            total++; if (rise_q[k] != 16) begin bad++; $display("FAIL single_rises%0d: got %0d want 16", k, rise_q[k]); end
            total++; if (fall_q[k] != 16) begin bad++; $display("FAIL single_falls%0d: got %0d want 16", k, fall_q[k]); end
        end
        total++; if (bad_edges != 0) begin bad++; $display("FAIL single_idle_edges: got %0d want 0", bad_edges); end
    endtask

    task automatic test_round_robin;
        int f1, r1, f2, r2, cc;
        logic [47:0] regs;
        logic [15:0] w;
        logic [2:0] exp_ch [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd0};
        do_reset();
        lft_v = 12'h300; rght_v = 12'h2F0; steer_v = 12'h800; batt_v = 12'hC00;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) lft_v = 12'h020;
            clear_logs();
            measure(-1, f1, r1, f2, r2, cc, regs);
            w = mosi_q[0];
            total++; if (w[13:11] !== exp_ch[k]) begin bad++; $display("FAIL rr_ch%0d: got %0d want %0d", k, w[13:11], exp_ch[k]); end
            total++; if (cc != 532) begin bad++; $display("FAIL rr_cmplt%0d: got %0d want 532", k, cc); end
            if (k == 3) begin
                total++; if (regs !== {12'h300, 12'h2F0, 12'h800, 12'hC00}) begin
                    bad++; $display("FAIL rr_all4: got %h want 3002f0800c00", regs); end
            end
            @(negedge clk);
        end
        total++; if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h020, 12'h2F0, 12'h800, 12'hC00}) begin
            bad++; $display("FAIL rr_update: got %h want 0202f0800c00", {lft_ld, rght_ld, steer_pot, batt}); end
    endtask

    task automatic test_busy_ignore;
        int f1, r1, f2, r2, cc, extra;
        logic [47:0] regs;
        logic [15:0] w;
        do_reset();
        lft_v = 12'h111; rght_v = 12'h7E7;
        measure(100, f1, r1, f2, r2, cc, regs);
        total++; if (cc != 532) begin bad++; $display("FAIL busy_cmplt: got %0d want 532", cc); end
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (!SS_n || cnv_cmplt) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL busy_queued: got %0d active cycles want 0", extra); end
        clear_logs();
        measure(-1, f1, r1, f2, r2, cc, regs);
        w = mosi_q[0];
        total++; if (w[13:11] !== 3'd4) begin bad++; $display("FAIL busy_ptr: got ch %0d want 4", w[13:11]); end
        total++; if (regs !== {12'h111, 12'h7E7, 24'h0}) begin bad++; $display("FAIL busy_regs: got %h want 1117e7000000", regs); end
    endtask

    task automatic test_back_to_back;
        int f1, r1, f2, r2, cc;
        logic [47:0] regs;
        logic [15:0] w;
        do_reset();
        lft_v = 12'h0AA; rght_v = 12'h0BB;
        measure(-1, f1, r1, f2, r2, cc, regs);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        total++; if (SS_n !== 1'b1) begin bad++; $display("FAIL b2b_done_ignore: got SS_n %b want 1", SS_n); end
        clear_logs();
        measure(-1, f1, r1, f2, r2, cc, regs);
        w = mosi_q[0];
        total++; if (f1 != 1) begin bad++; $display("FAIL b2b_accept: got %0d want 1", f1); end
        total++; if (w[13:11] !== 3'd4) begin bad++; $display("FAIL b2b_ch: got %0d want 4", w[13:11]); end
        total++; if (regs[35:24] !== 12'h0BB) begin bad++; $display("FAIL b2b_rght: got %h want 0bb", regs[35:24]); end
    endtask

    task automatic test_mid_reset;
        int f1, r1, f2, r2, cc, t0;
        logic [47:0] regs;
        logic [15:0] w;
        do_reset();
        lft_v = 12'h5A5;
        nxt = 1'b1;
        t0 = cyc;
        while (cyc - t0 < 300) begin
            @(negedge clk);
            nxt = 1'b0;
        end
        total++; if (SS_n !== 1'b0) begin bad++; $display("FAIL mid_in_read: got SS_n %b want 0", SS_n); end
        rst_n = 1'b0;
        #1;
        total++; if (SS_n !== 1'b1) begin bad++; $display("FAIL mid_ss_async: got %b want 1", SS_n); end
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL mid_sclk_async: got %b want 1", SCLK); end
        repeat (3) @(negedge clk);
        total++; if (cnv_cmplt !== 1'b0) begin bad++; $display("FAIL mid_cmplt: got %b want 0", cnv_cmplt); end
        total++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
            bad++; $display("FAIL mid_regs: got %h want 0", {lft_ld, rght_ld, steer_pot, batt}); end
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        measure(-1, f1, r1, f2, r2, cc, regs);
        w = mosi_q[0];
        total++; if (w[13:11] !== 3'd0) begin bad++; $display("FAIL mid_next_ch: got %0d want 0", w[13:11]); end
        total++; if (regs !== {12'h5A5, 36'h0}) begin bad++; $display("FAIL mid_next_val: got %h want 5a5000000000", regs); end
    endtask

`ifdef A2D_AUTO_NXT_EN
    task automatic test_auto_nxt;
        int t0, n;
        int exp_cc [4] = '{16915, 33299, 49683, 66067};
        int got_cc [4] = '{-1, -1, -1, -1};
        nxt = 1'b0;
        batt_v = 12'h650;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        t0 = cyc;
        n = 0;
        for (int i = 0; i < 66200 && n < 4; i++) begin
            @(negedge clk);
            if (cnv_cmplt) begin
                got_cc[n] = cyc - t0;
                n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (got_cc[k] != exp_cc[k]) begin bad++; $display("FAIL auto_cmplt%0d: got %0d want %0d", k, got_cc[k], exp_cc[k]); end
        end
        total++; if (batt !== 12'h650) begin bad++; $display("FAIL auto_batt: got %h want 650", batt); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef A2D_AUTO_NXT_EN
        test_auto_nxt();
`else
        test_single();
        test_round_robin();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/a2d_intf.md
# a2d_intf

Round-robin A2D interface between the Segway digital core and the ADC128S SPI converter. Each `nxt` request performs one two-transaction SPI conversion on the next channel in the sequence left load cell → right load cell → steering pot → battery. The result is latched into that channel's 12-bit holding register, and `cnv_cmplt` pulses. Downstream consumers are the rider-presence logic (`lft_ld`, `rght_ld`), steering enable (`steer_pot`) and the low-battery/piezo warning (`batt`).

## Interface
- `LFT_CH`, 3'd0: ADC channel for the left load cell
- `RGHT_CH`, 3'd4: ADC channel for the right load cell
- `STEER_CH`, 3'd5: ADC channel for the steering pot
- `BATT_CH`, 3'd6: ADC channel for the battery
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous active-low reset; output of rst_synch
- `nxt` in 1: start conversion of the next channel; honoured only in IDLE
- `MISO` in 1: serial data from the ADC
- `SS_n` out 1: ADC chip select, active low
- `SCLK` out 1: SPI clock, clk/16, idles high
- `MOSI` out 1: serial command to the ADC
- `lft_ld` out 12: last left load cell result
- `rght_ld` out 12: last right load cell result
- `steer_pot` out 12: last steering pot result
- `batt` out 12: last battery result
- `cnv_cmplt` out 1: one-cycle pulse when a holding register updates

## Operation
- Channel pointer: a 2-bit counter, 0→1→2→3→0, mapping to LFT/RGHT/STEER/BATT. It advances only when a conversion completes.
- Command word: {2'b00, ch[2:0], 11'h000}, shifted out MSB first.
- FSM states:
  - **IDLE**: on `nxt`, go to CMD.
  - **CMD**: run SPI transaction 1 with the command word; MISO data is discarded. On done, go to GAP.
  - **GAP**: SS_n held high for 2 clk, then go to READ.
  - **READ**: run SPI transaction 2. The same command word is sent again. Bits [11:0] of the 16 received bits are the result. On done, go to DONE.
  - **DONE**: write the result to the addressed holding register, pulse `cnv_cmplt`, advance the pointer, return to IDLE.
- SPI engine: a 4-bit divider `sdiv`, with `SCLK = sdiv[3]`.
  - On transaction start, `sdiv` is loaded with 4'b1000, so SCLK stays high for 8 clk of front porch.
  - MOSI presents bit 15 at the SS_n fall and shifts on each SCLK falling edge.
  - MISO is sampled into a 16-bit shift register in the clk where `sdiv` goes 4'b0111→4'b1000, i.e. on the SCLK rising edge.
  - After the 16th rising edge, SCLK stays high for 8 clk, then SS_n deasserts.
- Holding registers not addressed by the current conversion keep their values.
- `nxt` is ignored in every state other than IDLE; requests arriving while busy are not queued.

## Timing
- Reset values: SS_n=1, SCLK=1, MOSI=0, `cnv_cmplt`=0. All holding registers are 12'h000, the pointer is 0, and the state is IDLE.
- Reset is asynchronous: SS_n and SCLK return high in the same cycle rst_n falls, including mid-transaction. The partial conversion is discarded and no register updates.
- Cycle timeline, with `nxt` sampled high in IDLE at cycle 0:
  - Cycle 1: SS_n falls.
  - Transaction 1 holds SS_n low for 264 clk (8 front porch + 16×16).
  - Cycle 265: SS_n rises. It stays high during cycles 265–266.
  - Cycle 267: SS_n falls.
  - Cycle 531: SS_n rises.
  - Cycle 532: `cnv_cmplt` is high for exactly 1 clk, and the register holds the new value.
- Back-to-back: `nxt` asserted in the cycle `cnv_cmplt` is high is ignored, because the FSM is in DONE. It is accepted from the following cycle.
- Exactly 16 SCLK falling edges and 16 rising edges occur per SS_n low period. No SCLK edges occur while SS_n is high.

## Configuration
- Macro: `A2D_AUTO_NXT_EN`.
- Defined:
  - An internal 14-bit free-running counter generates a one-cycle internal `nxt` each time it wraps, i.e. every 16384 clk.
  - The `nxt` port is ignored.
  - The counter resets to 0, so the first auto request occurs at cycle 16383 after reset release.
- Undefined: conversions start only from the `nxt` port. No timer logic is present.

## Test plan
- **Reset**: hold rst_n low, with the ADC128S model driving any values → SS_n=1, SCLK=1, all outputs 0, `cnv_cmplt`=0.
- **Single conversion**: model ld_cell_lft=12'h300, pulse `nxt` → SS_n low for 264 clk twice with a 2-clk gap. First MOSI word is 16'h0000, 16 SCLK edges each. `cnv_cmplt` arrives at cycle 532 with `lft_ld`=12'h300; other registers remain 0.
- **Round robin**: model values lft=12'h300, rght=12'h2F0, steer=12'h800, batt=12'hC00. Issue 5 `nxt` pulses, each after `cnv_cmplt` → MOSI channel fields are 0,4,5,6,0, and all four registers match. Change lft to 12'h020 before the 5th pulse → `lft_ld`=12'h020.
- **Busy ignore**: pulse `nxt` at cycle 0 and again at cycle 100 → exactly one `cnv_cmplt`, and the pointer advances by 1.
- **Mid-op reset**: assert rst_n at cycle 300 (inside READ) → SS_n high immediately, no `cnv_cmplt`, registers 0. After release, the next `nxt` converts the left channel.
- **`A2D_AUTO_NXT_EN`**: with `nxt` tied 0, batt=12'h650 → conversions start at cycles 16383, 32767, 49151, 65535. After the 4th conversion, `batt`=12'h650.
